// File: rtl/conv_output_writer.sv
// Output collector for the binary convolution array: majority-votes each pixel's
// negative flags into a sign bit and packs sign bits into 16-bit SRAM words.
module conv_output_writer #(
    parameter int NUM_PE = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [NUM_PE-1:0] negative_flags,
    input  logic [11:0]       write_addr_in,
    input  logic [3:0]        idx_in,
    input  logic              last_in,
    output logic              sram_write_enable,
    output logic [11:0]       sram_write_address,
    output logic [15:0]       sram_write_data,
    output logic              done,
    output logic              error
);

    localparam int CW = $clog2(NUM_PE + 1);
    localparam logic [CW-1:0] HALF = CW'(NUM_PE / 2);

    logic [CW-1:0] cnt_d;
    logic          s1_vld_q;
    logic [CW-1:0] s1_cnt_q;
    logic [11:0]   s1_addr_q;
    logic [3:0]    s1_idx_q;
    logic          s1_last_q;

    logic [15:0]   buf_data_q, buf_data_d;
    logic [11:0]   buf_addr_q, buf_addr_d;
    logic          buf_full_q, buf_full_d;

    logic          we_q, we_d;
    logic [11:0]   waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          sign;
    logic          hit;
    logic [15:0]   merged;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cnt_d = cnt_d + CW'(negative_flags[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_cnt_q  <= '0;
            s1_addr_q <= '0;
            s1_idx_q  <= '0;
            s1_last_q <= 1'b0;
        end else begin
            s1_vld_q <= valid_in;
            if (valid_in) begin
                s1_cnt_q  <= cnt_d;
                s1_addr_q <= write_addr_in;
                s1_idx_q  <= idx_in;
                s1_last_q <= last_in;
            end
        end
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        buf_full_d = buf_full_q;
        we_d       = 1'b0;
        waddr_d    = '0;
        wdata_d    = '0;
        done_d     = 1'b0;
        err_d      = err_q;
        sign       = (s1_cnt_q <= HALF);
        hit        = buf_full_q && (buf_addr_q == s1_addr_q);
        merged     = hit ? buf_data_q : '0;
        merged[~s1_idx_q] = sign;
        if (s1_vld_q) begin
            // A foreign address while a word is open drops the old bits.
            if (buf_full_q && !hit) begin
                err_d = 1'b1;
            end
            if (s1_idx_q == 4'hF || s1_last_q) begin
                we_d       = 1'b1;
                waddr_d    = s1_addr_q;
                wdata_d    = merged;
                done_d     = s1_last_q;
                buf_data_d = '0;
                buf_addr_d = '0;
                buf_full_d = 1'b0;
            end else begin
                buf_data_d = merged;
                buf_addr_d = s1_addr_q;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_data_q <= '0;
            buf_addr_q <= '0;
            buf_full_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
            buf_full_q <= buf_full_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign sram_write_enable  = we_q;
    assign sram_write_address = waddr_q;
    assign sram_write_data    = wdata_q;
    assign done               = done_q;
    assign error              = err_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Directed bench for conv_output_writer with NUM_PE = 9.
// Expected words are hand-computed from the majority rule (sign 1 when <= 4 flags).
module tb_conv_output_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [8:0]  negative_flags;
    logic [11:0] write_addr_in;
    logic [3:0]  idx_in;
    logic        last_in;
    logic        sram_write_enable;
    logic [11:0] sram_write_address;
    logic [15:0] sram_write_data;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int wc0;

    localparam logic [8:0] F0 = 9'h000;
    localparam logic [8:0] FA = 9'h1FF;
    localparam logic [8:0] F4 = 9'h00F;
    localparam logic [8:0] F5 = 9'h01F;

    conv_output_writer #(.NUM_PE(9)) dut (
        .clock              (clock),
        .reset              (reset),
        .valid_in           (valid_in),
        .negative_flags     (negative_flags),
        .write_addr_in      (write_addr_in),
        .idx_in             (idx_in),
        .last_in            (last_in),
        .sram_write_enable  (sram_write_enable),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .done               (done),
        .error              (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sram_write_enable) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [8:0] f, input logic [11:0] a,
                       input logic [3:0] i, input logic l);
        valid_in       = 1'b1;
        negative_flags = f;
        write_addr_in  = a;
        idx_in         = i;
        last_in        = l;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        last_in  = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] a,
                          input logic [15:0] d, input logic dn);
        chk({tag, "_we"}, 32'(sram_write_enable), 32'd1);
        chk({tag, "_addr"}, 32'(sram_write_address), 32'(a));
        chk({tag, "_data"}, 32'(sram_write_data), 32'(d));
        chk({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        reset          = 1'b1;
        valid_in       = 1'b0;
        negative_flags = '0;
        write_addr_in  = '0;
        idx_in         = '0;
        last_in        = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_we", 32'(sram_write_enable), 32'd0);
        chk("rst_addr", 32'(sram_write_address), 32'd0);
        chk("rst_data", 32'(sram_write_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        reset = 1'b0;
        idle();

        // Full word of sign 1 bits.
        wc0 = wr_cnt;
        for (int i = 0; i < 16; i++) pix(F0, 12'h005, 4'(i), 1'b0);
        chk("t1_latency", 32'(sram_write_enable), 32'd0);
        idle();
        chk_wr("t1", 12'h005, 16'hFFFF, 1'b0);
        idle();
        chk("t1_we_low", 32'(sram_write_enable), 32'd0);
        chk("t1_addr_low", 32'(sram_write_address), 32'd0);
        chk("t1_data_low", 32'(sram_write_data), 32'd0);
        chk("t1_wcount", 32'(wr_cnt - wc0), 32'd1);

        // Majority threshold: 4 of 9 -> 1, 5 of 9 -> 0.
        pix(F4, 12'h001, 4'd0, 1'b0);
        pix(F5, 12'h001, 4'd1, 1'b0);
        for (int i = 2; i < 16; i++) pix(FA, 12'h001, 4'(i), 1'b0);
        idle();
        chk_wr("t2", 12'h001, 16'h8000, 1'b0);

        // Partial word by last_in, with an idle gap and an idx overwrite.
        pix(F0, 12'h0A0, 4'd0, 1'b0);
        pix(FA, 12'h0A0, 4'd1, 1'b0);
        pix(FA, 12'h0A0, 4'd2, 1'b0);
        idle();
        pix(F0, 12'h0A0, 4'd2, 1'b0);
        pix(F0, 12'h0A0, 4'd3, 1'b0);
        pix(FA, 12'h0A0, 4'd4, 1'b0);
        pix(F0, 12'h0A0, 4'd5, 1'b1);
        chk("t3_early_done", 32'(done), 32'd0);
        idle();
        chk_wr("t3", 12'h0A0, 16'hB400, 1'b1);
        chk("t3_err", 32'(error), 32'd0);
        idle();
        chk("t3_done_pulse", 32'(done), 32'd0);

        // Address change mid-word: error, old word dropped.
        wc0 = wr_cnt;
        for (int i = 0; i < 4; i++) pix(F0, 12'h010, 4'(i), 1'b0);
        pix(F0, 12'h011, 4'd0, 1'b0);
        pix(FA, 12'h011, 4'd1, 1'b0);
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_no_wr", 32'(sram_write_enable), 32'd0);
        for (int i = 2; i < 16; i++)
            pix((i % 2 == 0) ? F0 : FA, 12'h011, 4'(i), 1'b0);
        idle();
        chk_wr("t4", 12'h011, 16'hAAAA, 1'b0);
        idle();
        chk("t4_wcount", 32'(wr_cnt - wc0), 32'd1);
        chk("t4_err_sticky", 32'(error), 32'd1);

        // Reset mid-word discards buffered bits.
        for (int i = 0; i < 10; i++) pix(F0, 12'h020, 4'(i), 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_rst_we", 32'(sram_write_enable), 32'd0);
        chk("t5_rst_addr", 32'(sram_write_address), 32'd0);
        chk("t5_rst_data", 32'(sram_write_data), 32'd0);
        chk("t5_rst_err", 32'(error), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wc0 = wr_cnt;
        for (int i = 0; i < 16; i++)
            pix((i < 10) ? FA : F0, 12'h020, 4'(i), 1'b0);
        idle();
        chk_wr("t5", 12'h020, 16'h003F, 1'b0);
        idle();
        chk("t5_wcount", 32'(wr_cnt - wc0), 32'd1);

        // Back-to-back words.
        for (int i = 0; i < 16; i++)
            pix((i < 8) ? F0 : FA, 12'h030, 4'(i), 1'b0);
        pix(FA, 12'h031, 4'd0, 1'b0);
        chk_wr("t6a", 12'h030, 16'hFF00, 1'b0);
        for (int i = 1; i < 16; i++)
            pix((i < 8) ? FA : F0, 12'h031, 4'(i), 1'b0);
        pix(F0, 12'h032, 4'd0, 1'b1);
        chk_wr("t6b", 12'h031, 16'h00FF, 1'b0);
        idle();
        chk_wr("t6c", 12'h032, 16'h8000, 1'b1);
        idle();
        chk("t6_err", 32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_output_writer.md
# conv_output_writer

Back-end collector for the binary convolution array. Each cycle it accepts the NUM_PE per-element negative flags of one output pixel together with that pixel's pipelined write address and bit index. It reduces the flags to one sign bit by majority and packs sign bits into 16-bit words. Each completed word is issued as a single-cycle write to the output SRAM.

## Interface

Parameters:
- NUM_PE, 9: number of processing-element negative flags per pixel (1..15).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- valid_in  in  1  qualifies negative_flags, write_addr_in, idx_in and last_in this cycle.
- negative_flags  in  NUM_PE  per-element product sign; 1 = product of -1.
- write_addr_in  in  12  SRAM word address the pixel belongs to.
- idx_in  in  4  bit position of the pixel within the word.
- last_in  in  1  final pixel of the layer; forces a write of the partial word.
- sram_write_enable  out  1  one-cycle write strobe.
- sram_write_address  out  12  word address; valid while sram_write_enable is 1.
- sram_write_data  out  16  packed word; valid while sram_write_enable is 1.
- done  out  1  one-cycle pulse coincident with the write caused by last_in.
- error  out  1  sticky protocol-error flag.

## Operation

- Stage 1 registers the valid_in fields and a count: neg_count = popcount(negative_flags), width $clog2(NUM_PE+1).
- Sign bit: 1 when neg_count <= NUM_PE/2 (integer division), else 0. This means the ±1 dot product is >= 0 for odd NUM_PE; for even NUM_PE a tie yields 1.
- Word buffer: 16 data bits, a 12-bit address and a nonempty flag. All are 0 at reset.
- When a valid stage-1 pixel is present, its sign bit is placed at buffer bit [15 - idx]; idx 0 is the MSB.
- Address field:
  - Buffer empty: the address is taken from the pixel.
  - Buffer nonempty, addresses match: the bit merges into the existing word.
  - Buffer nonempty, addresses differ: error is set; old bits are discarded without a write; the buffer restarts with the new bit and new address.
- Same idx received twice for one word: the later bit overwrites the earlier one. No error is raised.
- Write trigger, when the stage-1 pixel has idx == 15 or last_in == 1:
  - On the next edge, sram_write_enable = 1, sram_write_address = buffer address, and sram_write_data = merged word including the current bit.
  - The buffer is then cleared to all-zero and empty.
- Bits never written in a flushed word are 0.
- last_in without idx 15 flushes a partial word. done pulses in the same cycle as that write.
- A valid_in == 0 cycle leaves the buffer untouched.
- error holds at 1 until reset.

## Timing

- Latency: valid_in sampled at edge E lands in stage 1; the resulting write is visible in the cycle after edge E+1.
- Throughput: one pixel per cycle, no backpressure. Back-to-back words write in consecutive cycles without bubbles.
- Reset values: sram_write_enable 0, sram_write_address 0, sram_write_data 0, done 0, error 0. Stage 1 and the buffer are empty.
- Reset asserted mid-word: buffered bits are lost; no write is issued, including one that was due on the next edge.
- sram_write_enable and done are high for exactly one cycle per trigger. Address and data return to 0 when enable is low.

## Test plan

- 16 pixels to address 0x005, idx 0..15, all flags 0 → single write at cycle 17: address 0x005, data 0xFFFF, done 0.
- NUM_PE = 9: one pixel with 4 flags set and idx 0, then one with 5 flags set and idx 1, then idx 2..15 with all flags set → write data 0x8000.
- Pixels idx 0..5 to address 0x0A0 with last_in on idx 5, sign bits 1,0,1,1,0,1 → data 0xB400, done pulses with the write, error 0.
- idx 0..3 to 0x010, then a pixel to 0x011 → error rises, no write of 0x010. Completing 0x011 through idx 15 yields a write to 0x011 only.
- Reset asserted after idx 0..9 of a word, then 16 fresh pixels to 0x020 → exactly one write to 0x020. The earlier bits do not appear in it, and all outputs read 0 during reset.
- Two words to 0x030 and 0x031 streamed with no gap → writes in consecutive cycles with correct data for both.
